// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: FSM states, flag bit
// positions, default ALU widths and opSel encodings.
package alu_share_arbiter_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 4;

  // Bit positions inside the 3-bit {carry, sign, zero} flag bundle
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_ZERO  = 0;

  localparam logic [ALU_OPW-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_OP_AND = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_OP_OR  = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_OP_XOR = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic [2:0] pack_flags(input logic carry, input logic sign,
                                            input logic zero);
    logic [2:0] f;
    f             = '0;
    f[FLAG_CARRY] = carry;
    f[FLAG_SIGN]  = sign;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_picker.sv
// Two-way round-robin picker: one-hot grant among valid requesters, the
// requester that was not granted last wins a tie.
module alu_rr_picker (
  input  logic [1:0] valid,
  input  logic       lastGnt,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this block latch-free.
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGnt ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin pick,
// registered operands, one settle cycle, then a held valid/ready response.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValid0,
  input  logic             reqValid1,
  output logic             reqReady0,
  output logic             reqReady1,
  input  logic [WIDTH-1:0] reqA0,
  input  logic [WIDTH-1:0] reqA1,
  input  logic [WIDTH-1:0] reqB0,
  input  logic [WIDTH-1:0] reqB1,
  input  logic [OPW-1:0]   reqOp0,
  input  logic [OPW-1:0]   reqOp1,
  output logic             rspValid0,
  output logic             rspValid1,
  input  logic             rspReady0,
  input  logic             rspReady1,
  output logic [WIDTH-1:0] rspResult,
  output logic [2:0]       rspFlags,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [OPW-1:0]   aluOpSel,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluCarry,
  input  logic             aluSign,
  input  logic             aluZero
);

  arb_state_t state;
  logic       last_gnt;
  logic       gnt_id;
  logic [1:0] pick_valid;
  logic [1:0] grant;
  logic [1:0] rsp_valid;
  logic       rsp_hs;

  // Requests are only offered to the picker while idle and out of reset
  assign pick_valid = (state == ST_IDLE && !rst) ? {reqValid1, reqValid0} : 2'b00;

  alu_rr_picker u_picker (
    .valid   (pick_valid),
    .lastGnt (last_gnt),
    .grant   (grant)
  );

  assign reqReady0 = grant[0];
  assign reqReady1 = grant[1];
  assign rspValid0 = rsp_valid[0];
  assign rspValid1 = rsp_valid[1];

  // Only the granted requester's rspReady can complete the response
  assign rsp_hs = gnt_id ? (rsp_valid[1] & rspReady1) : (rsp_valid[0] & rspReady0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_gnt  <= 1'b1;
      gnt_id    <= 1'b0;
      aluA      <= '0;
      aluB      <= '0;
      aluOpSel  <= '0;
      rspResult <= '0;
      rspFlags  <= '0;
      rsp_valid <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            aluA     <= grant[1] ? reqA1  : reqA0;
            aluB     <= grant[1] ? reqB1  : reqB0;
            aluOpSel <= grant[1] ? reqOp1 : reqOp0;
            gnt_id   <= grant[1];
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rspResult <= aluResult;
          rspFlags  <= pack_flags(aluCarry, aluSign, aluZero);
          rsp_valid <= gnt_id ? 2'b10 : 2'b01;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            rsp_valid <= 2'b00;
            last_gnt  <= gnt_id;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a behavioural ALU and per-requester
// scoreboards of expected {result, flags}.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int W      = 32;
  localparam int OPW    = 4;
  localparam int N_RAND = 10000;
  localparam int LIMIT  = 80000;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid0, reqValid1, reqReady0, reqReady1;
  logic [W-1:0]  reqA0, reqA1, reqB0, reqB1;
  logic [OPW-1:0] reqOp0, reqOp1;
  logic          rspValid0, rspValid1, rspReady0, rspReady1;
  logic [W-1:0]  rspResult;
  logic [2:0]    rspFlags;
  logic [W-1:0]  aluA, aluB, aluResult;
  logic [OPW-1:0] aluOpSel;
  logic          aluCarry, aluSign, aluZero;

  int errors = 0;
  int checks = 0;
  logic [W+2:0] q0[$];
  logic [W+2:0] q1[$];

  always #5 clk = ~clk;

  // Returns {result, carry, sign, zero}
  function automatic logic [W+2:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [OPW-1:0] op);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c;
    t = '0;
    r = '0;
    c = 1'b0;
    case (op)
      ALU_OP_ADD: begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W]; end
      ALU_OP_SUB: begin t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; c = t[W]; end
      ALU_OP_AND: r = a & b;
      ALU_OP_OR:  r = a | b;
      ALU_OP_XOR: r = a ^ b;
      default:    r = '0;
    endcase
    return {r, c, r[W-1], (r == '0)};
  endfunction

  always_comb {aluResult, aluCarry, aluSign, aluZero} = alu_model(aluA, aluB, aluOpSel);

  alu_share_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .reqValid0(reqValid0), .reqValid1(reqValid1),
    .reqReady0(reqReady0), .reqReady1(reqReady1),
    .reqA0(reqA0), .reqA1(reqA1), .reqB0(reqB0), .reqB1(reqB1),
    .reqOp0(reqOp0), .reqOp1(reqOp1),
    .rspValid0(rspValid0), .rspValid1(rspValid1),
    .rspReady0(rspReady0), .rspReady1(rspReady1),
    .rspResult(rspResult), .rspFlags(rspFlags),
    .aluA(aluA), .aluB(aluB), .aluOpSel(aluOpSel),
    .aluResult(aluResult), .aluCarry(aluCarry), .aluSign(aluSign), .aluZero(aluZero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bounded waits; return -1 on timeout, caller compares the id
  task automatic wait_grant(output int id);
    int n = 0;
    @(negedge clk);
    while (!(reqReady0 || reqReady1) && n < 10) begin
      tick;
      @(negedge clk);
      n++;
    end
    id = reqReady1 ? 1 : (reqReady0 ? 0 : -1);
  endtask

  task automatic wait_rsp(output int id);
    int n = 0;
    @(negedge clk);
    while (!(rspValid0 || rspValid1) && n < 20) begin
      tick;
      @(negedge clk);
      n++;
    end
    id = rspValid1 ? 1 : (rspValid0 ? 0 : -1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    reqValid0 = 1'b1; reqValid1 = 1'b1;
    reqA0 = 32'h1234; reqB0 = 32'h1; reqOp0 = ALU_OP_ADD;
    reqA1 = 32'h5678; reqB1 = 32'h2; reqOp1 = ALU_OP_SUB;
    rspReady0 = 1'b1; rspReady1 = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if ({reqReady1, reqReady0} !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 00", {reqReady1, reqReady0});
    end
    checks++;
    if ({rspValid1, rspValid0} !== 2'b00) begin
      errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {rspValid1, rspValid0});
    end
    checks++;
    if ({rspResult, rspFlags} !== '0) begin
      errors++; $display("FAIL reset_rsp_data: got %h/%b expected 0/000", rspResult, rspFlags);
    end
    checks++;
    if ({aluA, aluB, aluOpSel} !== '0) begin
      errors++; $display("FAIL reset_alu_regs: got %h %h %h expected 0", aluA, aluB, aluOpSel);
    end
    reqValid0 = 1'b0; reqValid1 = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_req0;
    logic [W+2:0] exp;
    reqA0 = 32'h5; reqB0 = 32'h3; reqOp0 = ALU_OP_ADD; reqValid0 = 1'b1;
    q0.push_back(alu_model(reqA0, reqB0, reqOp0));
    @(negedge clk);
    checks++;
    if ({reqReady1, reqReady0} !== 2'b01) begin
      errors++; $display("FAIL single_grant: got %b expected 01", {reqReady1, reqReady0});
    end
    tick;
    reqValid0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rspValid1, rspValid0} !== 2'b00) begin
      errors++; $display("FAIL single_exec_cycle: got %b expected 00", {rspValid1, rspValid0});
    end
    tick;
    @(negedge clk);
    checks++;
    if ({rspValid1, rspValid0} !== 2'b01) begin
      errors++; $display("FAIL single_latency: got %b expected 01 at N+2", {rspValid1, rspValid0});
    end
    exp = q0.pop_front();
    checks++;
    if ({rspResult, rspFlags} !== {32'h8, 3'b000} || {rspResult, rspFlags} !== exp) begin
      errors++; $display("FAIL single_data: got %h/%b expected 8/000", rspResult, rspFlags);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({rspValid1, rspValid0} !== 2'b00) begin
      errors++; $display("FAIL single_complete: got %b expected 00", {rspValid1, rspValid0});
    end
    tick;
  endtask

  task automatic test_tie;
    int gid, rid, exp_id;
    logic [W+2:0] exp;
    rst = 1'b1;
    reqA0 = 32'd10; reqB0 = 32'd20; reqOp0 = ALU_OP_ADD;
    reqA1 = 32'd50; reqB1 = 32'd7;  reqOp1 = ALU_OP_SUB;
    reqValid0 = 1'b1; reqValid1 = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({reqReady1, reqReady0} !== 2'b01) begin
      errors++; $display("FAIL tie_first_after_reset: got %b expected 01", {reqReady1, reqReady0});
    end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      wait_grant(gid);
      checks++;
      if (gid !== exp_id) begin
        errors++; $display("FAIL tie_grant_%0d: got %0d expected %0d", k, gid, exp_id);
      end
      if (gid == 0) q0.push_back(alu_model(reqA0, reqB0, reqOp0));
      if (gid == 1) q1.push_back(alu_model(reqA1, reqB1, reqOp1));
      tick;
      if (gid == 0) begin reqA0 = reqA0 + 32'd3; reqB0 = reqB0 + 32'd1; end
      if (gid == 1) begin reqA1 = reqA1 + 32'd3; reqB1 = reqB1 + 32'd1; end
      wait_rsp(rid);
      checks++;
      if (rid !== exp_id || (rid == 0 && q0.size() == 0) || (rid == 1 && q1.size() == 0)) begin
        errors++; $display("FAIL tie_rsp_%0d: got rsp id %0d expected %0d", k, rid, exp_id);
      end else begin
        exp = (rid == 0) ? q0.pop_front() : q1.pop_front();
        checks++;
        if ({rspResult, rspFlags} !== exp) begin
          errors++; $display("FAIL tie_data_%0d: got %h expected %h", k, {rspResult, rspFlags}, exp);
        end
      end
      tick;
    end
    reqValid0 = 1'b0; reqValid1 = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_backpressure;
    int gid, rid;
    logic [W+2:0] exp;
    rspReady0 = 1'b0;
    reqA0 = 32'h11; reqB0 = 32'h22; reqOp0 = ALU_OP_ADD; reqValid0 = 1'b1;
    wait_grant(gid);
    checks++;
    if (gid !== 0) begin
      errors++; $display("FAIL bp_grant: got %0d expected 0", gid);
    end
    exp = alu_model(reqA0, reqB0, reqOp0);
    q0.push_back(exp);
    tick;
    reqValid0 = 1'b0;
    reqA1 = 32'h100; reqB1 = 32'h200; reqOp1 = ALU_OP_OR; reqValid1 = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({rspValid1, rspValid0, reqReady1, reqReady0} !== 4'b0100) begin
        errors++; $display("FAIL bp_hold_ctrl_%0d: got %b expected 0100", i,
                           {rspValid1, rspValid0, reqReady1, reqReady0});
      end
      checks++;
      if ({rspResult, rspFlags, aluA, aluB} !== {exp, 32'h11, 32'h22}) begin
        errors++; $display("FAIL bp_hold_data_%0d: got %h %h %h", i, {rspResult, rspFlags}, aluA, aluB);
      end
      tick;
    end
    rspReady0 = 1'b1;
    @(negedge clk);
    if (q0.size() > 0) void'(q0.pop_front());
    checks++;
    if (rspValid0 !== 1'b1 || {rspResult, rspFlags} !== exp) begin
      errors++; $display("FAIL bp_release: got valid %b data %h expected 1 %h", rspValid0,
                         {rspResult, rspFlags}, exp);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({rspValid0, reqReady1} !== 2'b01) begin
      errors++; $display("FAIL bp_complete: got valid0/ready1 %b expected 01", {rspValid0, reqReady1});
    end
    q1.push_back(alu_model(reqA1, reqB1, reqOp1));
    tick;
    reqValid1 = 1'b0;
    wait_rsp(rid);
    checks++;
    if (rid !== 1 || q1.size() == 0) begin
      errors++; $display("FAIL bp_next_rsp: got id %0d expected 1", rid);
    end else begin
      exp = q1.pop_front();
      checks++;
      if ({rspResult, rspFlags} !== exp) begin
        errors++; $display("FAIL bp_next_data: got %h expected %h", {rspResult, rspFlags}, exp);
      end
    end
    tick;
  endtask

  task automatic test_flags;
    int gid, rid;
    logic [W+2:0] exp;
    reqA1 = 32'hFFFF_FFFF; reqB1 = 32'h1; reqOp1 = ALU_OP_ADD; reqValid1 = 1'b1;
    wait_grant(gid);
    checks++;
    if (gid !== 1) begin
      errors++; $display("FAIL flags_grant: got %0d expected 1", gid);
    end
    q1.push_back(alu_model(reqA1, reqB1, reqOp1));
    tick;
    reqValid1 = 1'b0;
    wait_rsp(rid);
    checks++;
    if ({rspValid1, rspValid0} !== 2'b10) begin
      errors++; $display("FAIL flags_rsp_valid: got %b expected 10", {rspValid1, rspValid0});
    end
    exp = (q1.size() > 0) ? q1.pop_front() : '0;
    checks++;
    if ({rspResult, rspFlags} !== {32'h0, 3'b101} || {rspResult, rspFlags} !== exp) begin
      errors++; $display("FAIL flags_data: got %h/%b expected 0/101", rspResult, rspFlags);
    end
    tick;
  endtask

  task automatic test_reset_in_resp;
    int gid, rid;
    logic [W+2:0] exp;
    rspReady1 = 1'b0;
    reqA1 = 32'h7; reqB1 = 32'h9; reqOp1 = ALU_OP_XOR; reqValid1 = 1'b1;
    wait_grant(gid);
    tick;
    reqA1 = 32'h70; reqB1 = 32'h0F; reqOp1 = ALU_OP_SUB;
    wait_rsp(rid);
    checks++;
    if (rid !== 1) begin
      errors++; $display("FAIL rr_setup_rsp: got id %0d expected 1", rid);
    end
    tick;
    rst = 1'b1;
    reqA0 = 32'h2; reqB0 = 32'h3; reqOp0 = ALU_OP_AND; reqValid0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({reqReady1, reqReady0} !== 2'b00) begin
      errors++; $display("FAIL rr_ready_in_reset: got %b expected 00", {reqReady1, reqReady0});
    end
    tick;
    rst = 1'b0;
    rspReady1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({rspValid1, rspValid0, rspResult, rspFlags, aluA, aluB, aluOpSel} !== '0) begin
      errors++; $display("FAIL rr_outputs_cleared: got valid %b data %h alu %h %h %h expected 0",
                         {rspValid1, rspValid0}, {rspResult, rspFlags}, aluA, aluB, aluOpSel);
    end
    checks++;
    if ({reqReady1, reqReady0} !== 2'b01) begin
      errors++; $display("FAIL rr_tie_after_reset: got %b expected 01", {reqReady1, reqReady0});
    end
    q0.push_back(alu_model(reqA0, reqB0, reqOp0));
    tick;
    reqValid0 = 1'b0;
    for (int t = 0; t < 2; t++) begin
      wait_rsp(rid);
      checks++;
      if (rid !== t || (rid == 0 && q0.size() == 0) || (rid == 1 && q1.size() == 0)) begin
        errors++; $display("FAIL rr_rsp_%0d: got id %0d expected %0d", t, rid, t);
      end else begin
        exp = (rid == 0) ? q0.pop_front() : q1.pop_front();
        checks++;
        if ({rspResult, rspFlags} !== exp) begin
          errors++; $display("FAIL rr_data_%0d: got %h expected %h", t, {rspResult, rspFlags}, exp);
        end
      end
      tick;
      if (t == 0) begin
        wait_grant(gid);
        checks++;
        if (gid !== 1) begin
          errors++; $display("FAIL rr_req1_reaccept: got %0d expected 1", gid);
        end
        q1.push_back(alu_model(reqA1, reqB1, reqOp1));
        tick;
        reqValid1 = 1'b0;
      end
    end
  endtask

  task automatic test_random;
    int issued = 0, done = 0, cyc = 0;
    int waits[2] = '{0, 0};
    logic g0, g1;
    logic [W+2:0] exp;
    while ((issued < N_RAND || done < issued || reqValid0 || reqValid1) && cyc < LIMIT) begin
      if (!reqValid0 && issued < N_RAND && $urandom_range(1, 0) == 1) begin
        reqValid0 = 1'b1; reqA0 = $urandom; reqB0 = $urandom; reqOp0 = 4'($urandom_range(4, 0));
      end
      if (!reqValid1 && issued < N_RAND && $urandom_range(1, 0) == 1) begin
        reqValid1 = 1'b1; reqA1 = $urandom; reqB1 = $urandom; reqOp1 = 4'($urandom_range(4, 0));
      end
      rspReady0 = ($urandom_range(3, 0) != 0);
      rspReady1 = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      g0 = reqValid0 && reqReady0;
      g1 = reqValid1 && reqReady1;
      if (g0 || g1) begin
        if (g0) begin
          q0.push_back(alu_model(reqA0, reqB0, reqOp0));
          if (reqValid1) waits[1]++;
          waits[0] = 0;
        end
        if (g1) begin
          q1.push_back(alu_model(reqA1, reqB1, reqOp1));
          if (reqValid0) waits[0]++;
          waits[1] = 0;
        end
        issued++;
        checks++;
        if ((g0 && g1) || waits[0] > 1 || waits[1] > 1) begin
          errors++; $display("FAIL rand_grant: grants %b waits %0d/%0d expected one grant, waits<=1",
                             {g1, g0}, waits[0], waits[1]);
        end
      end
      if (rspValid0 || rspValid1) begin
        checks++;
        if ((rspValid0 && rspValid1) || (rspValid0 && q0.size() == 0) || (rspValid1 && q1.size() == 0)) begin
          errors++; $display("FAIL rand_rsp_valid: got %b with queues %0d/%0d",
                             {rspValid1, rspValid0}, q0.size(), q1.size());
        end else if ((rspValid0 && rspReady0) || (rspValid1 && rspReady1)) begin
          exp = rspValid0 ? q0.pop_front() : q1.pop_front();
          done++;
          checks++;
          if ({rspResult, rspFlags} !== exp) begin
            errors++; $display("FAIL rand_data_%0d: got %h expected %h", done, {rspResult, rspFlags}, exp);
          end
        end
      end
      tick;
      if (g0) reqValid0 = 1'b0;
      if (g1) reqValid1 = 1'b0;
      cyc++;
    end
    checks++;
    if (cyc >= LIMIT) begin
      errors++; $display("FAIL rand_timeout: got %0d cycles expected < %0d", cyc, LIMIT);
    end
    checks++;
    if (done !== issued || q0.size() + q1.size() !== 0) begin
      errors++; $display("FAIL rand_count: got %0d responses for %0d requests, %0d left queued",
                         done, issued, q0.size() + q1.size());
    end
    rspReady0 = 1'b1; rspReady1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    reqValid0 = 1'b0; reqValid1 = 1'b0;
    reqA0 = '0; reqA1 = '0; reqB0 = '0; reqB1 = '0;
    reqOp0 = '0; reqOp1 = '0;
    rspReady0 = 1'b1; rspReady1 = 1'b1;
    test_reset;
    test_single_req0;
    test_tie;
    test_backpressure;
    test_flags;
    test_reset_in_resp;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
